// File: rtl/datapath_pkg.sv
// Shared constants for the LabB execution datapath: word and address widths
// and the 3-bit ALU operation encodings driven by the processor controller.
package datapath_pkg;

  localparam int DATA_W = 16;
  localparam int RF_AW  = 4;
  localparam int RAM_AW = 8;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;
  localparam logic [2:0] ALU_XOR  = 3'd5;
  localparam logic [2:0] ALU_NOT  = 3'd6;
  localparam logic [2:0] ALU_INC  = 3'd7;

endpackage

// File: rtl/datapath_unit_rf.sv
// register_file_16x16: two registered read ports and two write ports.
// Port A write wins when both ports target the same address.
// Optional macro RF_BYPASS_EN: a read of an address being written in the same
// cycle returns the new write data; otherwise the read returns the old contents.
module register_file_16x16 #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     ra_addr,
  input  logic [AW-1:0]     rb_addr,
  input  logic              wen_a,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic              wen_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data
);

  logic [DATA_W-1:0] rf_q [DEPTH];
  logic [DATA_W-1:0] rf_d [DEPTH];
  logic [DATA_W-1:0] ra_q, ra_d;
  logic [DATA_W-1:0] rb_q, rb_d;

  // Next register contents: apply port B first so port A overrides on a clash.
  always_comb begin
    rf_d = rf_q;
    if (wen_b) rf_d[rb_addr] = wdata_b;
    if (wen_a) rf_d[ra_addr] = wdata_a;
`ifdef RF_BYPASS_EN
    ra_d = rf_d[ra_addr];
    rb_d = rf_d[rb_addr];
`else
    ra_d = rf_q[ra_addr];
    rb_d = rf_q[rb_addr];
`endif
  end

  // Register array and read registers; reset clears all and drops pending writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_q <= '{default: '0};
      ra_q <= '0;
      rb_q <= '0;
    end else begin
      rf_q <= rf_d;
      ra_q <= ra_d;
      rb_q <= rb_d;
    end
  end

  assign ra_data = ra_q;
  assign rb_data = rb_q;

endmodule

// File: rtl/datapath_unit.sv
// datapath_unit: LabB execution datapath -- 16x16 register file, 16-bit ALU
// and 256x16 data RAM with one-cycle registered reads on RF and RAM.
// Optional macro RF_BYPASS_EN selects write-through RF reads.
module datapath_unit #(
  parameter int DATA_W    = datapath_pkg::DATA_W,
  parameter int RF_DEPTH  = 1 << datapath_pkg::RF_AW,
  parameter int RAM_DEPTH = 1 << datapath_pkg::RAM_AW
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic [2:0]                   ALU_s,
  input  logic [$clog2(RAM_DEPTH)-1:0] D_addr,
  input  logic                         D_wr,
  input  logic [$clog2(RF_DEPTH)-1:0]  RF_Ra_addr,
  input  logic [$clog2(RF_DEPTH)-1:0]  RF_Rb_addr,
  input  logic                         RF_WenA,
  input  logic                         RF_WenB,
  output logic [DATA_W-1:0]            Ra_data,
  output logic [DATA_W-1:0]            Rb_data,
  output logic [DATA_W-1:0]            ALU_Out,
  output logic                         ALU_Z,
  output logic [DATA_W-1:0]            D_rdata
);

  import datapath_pkg::*;

  logic [DATA_W-1:0] alu_out;
  logic [DATA_W-1:0] ram_mem [RAM_DEPTH];
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  // Load path writes RAM data through port A; arith path writes ALU result through port B.
  register_file_16x16 #(
    .DATA_W (DATA_W),
    .DEPTH  (RF_DEPTH)
  ) u_rf (
    .clk     (Clk),
    .rst     (Reset),
    .ra_addr (RF_Ra_addr),
    .rb_addr (RF_Rb_addr),
    .wen_a   (RF_WenA),
    .wdata_a (d_rdata_q),
    .wen_b   (RF_WenB),
    .wdata_b (alu_out),
    .ra_data (Ra_data),
    .rb_data (Rb_data)
  );

  // ALU on the registered operands; arithmetic wraps modulo 2^DATA_W.
  always_comb begin
    alu_out = Ra_data;
    case (ALU_s)
      ALU_PASS: alu_out = Ra_data;
      ALU_ADD:  alu_out = Ra_data + Rb_data;
      ALU_SUB:  alu_out = Ra_data - Rb_data;
      ALU_AND:  alu_out = Ra_data & Rb_data;
      ALU_OR:   alu_out = Ra_data | Rb_data;
      ALU_XOR:  alu_out = Ra_data ^ Rb_data;
      ALU_NOT:  alu_out = ~Ra_data;
      ALU_INC:  alu_out = Ra_data + {{(DATA_W-1){1'b0}}, 1'b1};
      default:  alu_out = Ra_data;
    endcase
  end

  assign ALU_Out = alu_out;
  assign ALU_Z   = (alu_out == '0);

  // RAM store of the previously registered port A data; no reset so contents survive,
  // but a store whose cycle overlaps Reset is dropped.
  always_ff @(posedge Clk) begin
    if (D_wr && !Reset) ram_mem[D_addr] <= Ra_data;
  end

  // RAM read data selected before this cycle's write lands (read-before-write).
  always_comb begin
    d_rdata_d = ram_mem[D_addr];
  end

  // Registered RAM read port.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) d_rdata_q <= '0;
    else       d_rdata_q <= d_rdata_d;
  end

  assign D_rdata = d_rdata_q;

endmodule

// File: tb/tb_datapath_unit.sv
// Self-checking bench for datapath_unit: register values are built up through
// the ALU, moved via RAM stores/loads, and every output is checked against a
// bench-side RF/RAM model through an expected-value queue.
module tb_datapath_unit;

  localparam logic [2:0] S_PASS = 3'd0;
  localparam logic [2:0] S_ADD  = 3'd1;
  localparam logic [2:0] S_SUB  = 3'd2;
  localparam logic [2:0] S_INC  = 3'd7;
  localparam logic [2:0] S_NOT  = 3'd6;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [2:0]  ALU_s = '0;
  logic [7:0]  D_addr = '0;
  logic        D_wr = 1'b0;
  logic [3:0]  RF_Ra_addr = '0;
  logic [3:0]  RF_Rb_addr = '0;
  logic        RF_WenA = 1'b0;
  logic        RF_WenB = 1'b0;
  logic [15:0] Ra_data, Rb_data, ALU_Out, D_rdata;
  logic        ALU_Z;

  int tests = 0;
  int fails = 0;

  logic [15:0] rf_m [16];
  logic [15:0] ram_m [256];
  logic [15:0] exp_q [$];

  datapath_unit dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .ALU_s      (ALU_s),
    .D_addr     (D_addr),
    .D_wr       (D_wr),
    .RF_Ra_addr (RF_Ra_addr),
    .RF_Rb_addr (RF_Rb_addr),
    .RF_WenA    (RF_WenA),
    .RF_WenB    (RF_WenB),
    .Ra_data    (Ra_data),
    .Rb_data    (Rb_data),
    .ALU_Out    (ALU_Out),
    .ALU_Z      (ALU_Z),
    .D_rdata    (D_rdata)
  );

  // Clock
  always #5 Clk = ~Clk;

  function automatic logic [15:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] s);
    case (s)
      3'd0: return a;
      3'd1: return a + b;
      3'd2: return a - b;
      3'd3: return a & b;
      3'd4: return a | b;
      3'd5: return a ^ b;
      3'd6: return ~a;
      default: return a + 16'd1;
    endcase
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Read register a on both ports and compare against the model.
  task automatic read_reg(input logic [3:0] a);
    logic [15:0] e;
    RF_Ra_addr = a;
    RF_Rb_addr = a;
    exp_q.push_back(rf_m[a]);
    tick();
    e = exp_q.pop_front();
    tests++;
    if (Ra_data !== e) begin
      fails++;
      $display("FAIL read_ra R%0d: got %h expected %h", a, Ra_data, e);
    end
    tests++;
    if (Rb_data !== e) begin
      fails++;
      $display("FAIL read_rb R%0d: got %h expected %h", a, Rb_data, e);
    end
  endtask

  // Arith instruction: operands in cycle N, check ALU, write dst at end of N+1.
  task automatic alu_op(input logic [3:0] dst, input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] s);
    logic [15:0] e;
    RF_Ra_addr = a;
    RF_Rb_addr = b;
    ALU_s      = s;
    exp_q.push_back(alu_ref(rf_m[a], rf_m[b], s));
    tick();
    RF_Rb_addr = dst;
    RF_WenB    = 1'b1;
    #1;
    e = exp_q.pop_front();
    tests++;
    if (ALU_Out !== e || ALU_Z !== (e == 16'h0)) begin
      fails++;
      $display("FAIL alu_out sel=%0d R%0d,R%0d: got %h z=%b expected %h", s, a, b,
               ALU_Out, ALU_Z, e);
    end
    rf_m[dst] = e;
    tick();
    RF_WenB = 1'b0;
  endtask

  // Build an arbitrary value in register r by shift-and-increment through the ALU.
  task automatic set_reg(input logic [3:0] r, input logic [15:0] v);
    alu_op(r, r, r, S_SUB);
    for (int i = 15; i >= 0; i--) begin
      alu_op(r, r, r, S_ADD);
      if (v[i]) alu_op(r, r, r, S_INC);
    end
  endtask

  // Store: register a registered in N, RAM write in N+1.
  task automatic store(input logic [3:0] a, input logic [7:0] addr);
    RF_Ra_addr = a;
    tick();
    D_addr = addr;
    D_wr   = 1'b1;
    tick();
    D_wr = 1'b0;
    ram_m[addr] = rf_m[a];
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    ALU_s = S_INC;
    tick();
    tests++;
    if (Ra_data !== 16'h0 || Rb_data !== 16'h0 || D_rdata !== 16'h0) begin
      fails++;
      $display("FAIL reset_regs: got ra=%h rb=%h dr=%h expected 0000", Ra_data, Rb_data, D_rdata);
    end
    tests++;
    if (ALU_Out !== 16'h0001 || ALU_Z !== 1'b0) begin
      fails++;
      $display("FAIL reset_alu_inc: got %h z=%b expected 0001 z=0", ALU_Out, ALU_Z);
    end
    ALU_s = S_PASS;
    #1;
    tests++;
    if (ALU_Out !== 16'h0000 || ALU_Z !== 1'b1) begin
      fails++;
      $display("FAIL reset_alu_pass: got %h z=%b expected 0000 z=1", ALU_Out, ALU_Z);
    end
    Reset = 1'b0;
    for (int i = 0; i < 16; i++) rf_m[i] = 16'h0;
    for (int i = 0; i < 16; i++) read_reg(4'(i));
  endtask

  task automatic test_load();
    set_reg(4'd6, 16'h1234);
    store(4'd6, 8'h10);
    D_addr = 8'h10;
    exp_q.push_back(ram_m[8'h10]);
    tick();
    tests++;
    if (D_rdata !== exp_q[0]) begin
      fails++;
      $display("FAIL load_rdata: got %h expected %h", D_rdata, exp_q[0]);
    end
    void'(exp_q.pop_front());
    RF_Ra_addr = 4'd3;
    RF_WenA    = 1'b1;
    tick();
    RF_WenA = 1'b0;
    rf_m[3] = ram_m[8'h10];
    tick();
    read_reg(4'd3);
  endtask

  task automatic test_arith();
    alu_op(4'd1, 4'd0, 4'd0, S_NOT);   // R1 = 0xFFFF
    alu_op(4'd2, 4'd0, 4'd0, S_INC);   // R2 = 0x0001
    alu_op(4'd5, 4'd1, 4'd2, S_ADD);   // wraps to 0, ALU_Z checked inside
    read_reg(4'd5);
    alu_op(4'd5, 4'd1, 4'd2, S_SUB);   // 0xFFFE
    read_reg(4'd5);
    alu_op(4'd5, 4'd0, 4'd2, S_SUB);   // 0 - 1 = 0xFFFF
    read_reg(4'd5);
    set_reg(4'd8, 16'(32'($urandom_range(0, 65535))));
    set_reg(4'd9, 16'(32'($urandom_range(0, 65535))));
    for (int s = 0; s < 8; s++) begin
      alu_op(4'd10, 4'd8, 4'd9, 3'(s));
      read_reg(4'd10);
    end
  endtask

  task automatic test_store();
    logic [15:0] e;
    store(4'd6, 8'h80);                // known old contents 0x1234
    set_reg(4'd4, 16'hBEEF);
    RF_Ra_addr = 4'd4;
    tick();
    D_addr = 8'h80;
    D_wr   = 1'b1;
    exp_q.push_back(ram_m[8'h80]);
    tick();
    D_wr = 1'b0;
    ram_m[8'h80] = rf_m[4];
    e = exp_q.pop_front();
    tests++;
    if (D_rdata !== e) begin
      fails++;
      $display("FAIL store_rbw: got %h expected %h", D_rdata, e);
    end
    exp_q.push_back(ram_m[8'h80]);
    tick();
    e = exp_q.pop_front();
    tests++;
    if (D_rdata !== e) begin
      fails++;
      $display("FAIL store_read: got %h expected %h", D_rdata, e);
    end
  endtask

  task automatic test_dual_write();
    logic [15:0] e;
    set_reg(4'd10, 16'h00AA);
    store(4'd10, 8'h20);
    set_reg(4'd11, 16'h0055);
    set_reg(4'd7, 16'h0033);
    D_addr     = 8'h20;
    RF_Ra_addr = 4'd11;
    RF_Rb_addr = 4'd0;
    ALU_s      = S_PASS;
    tick();
    RF_Ra_addr = 4'd7;
    RF_Rb_addr = 4'd7;
    RF_WenA    = 1'b1;
    RF_WenB    = 1'b1;
`ifdef RF_BYPASS_EN
    exp_q.push_back(ram_m[8'h20]);
`else
    exp_q.push_back(rf_m[7]);
`endif
    tick();
    RF_WenA = 1'b0;
    RF_WenB = 1'b0;
    rf_m[7] = ram_m[8'h20];
    e = exp_q.pop_front();
    tests++;
    if (Ra_data !== e || Rb_data !== e) begin
      fails++;
      $display("FAIL dual_same_cycle_read: got ra=%h rb=%h expected %h", Ra_data, Rb_data, e);
    end
    read_reg(4'd7);
    // Different addresses: both writes land.
    RF_Ra_addr = 4'd11;
    RF_Rb_addr = 4'd0;
    ALU_s      = S_PASS;
    tick();
    RF_Ra_addr = 4'd12;
    RF_Rb_addr = 4'd13;
    RF_WenA    = 1'b1;
    RF_WenB    = 1'b1;
    tick();
    RF_WenA = 1'b0;
    RF_WenB = 1'b0;
    rf_m[12] = ram_m[8'h20];
    rf_m[13] = rf_m[11];
    read_reg(4'd12);
    read_reg(4'd13);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++)
      alu_op(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
    for (int i = 0; i < 16; i++) read_reg(4'(i));
  endtask

  task automatic test_async_reset();
    RF_Ra_addr = 4'd3;
    RF_Rb_addr = 4'd3;
    ALU_s      = S_INC;
    tick();
    RF_Rb_addr = 4'd14;
    RF_WenB    = 1'b1;
    #2;
    Reset = 1'b1;
    #1;
    tests++;
    if (Ra_data !== 16'h0 || Rb_data !== 16'h0) begin
      fails++;
      $display("FAIL async_reset_clear: got ra=%h rb=%h expected 0000", Ra_data, Rb_data);
    end
    tick();
    RF_WenB = 1'b0;
    #2;
    Reset = 1'b0;
    for (int i = 0; i < 16; i++) rf_m[i] = 16'h0;
    read_reg(4'd14);
    read_reg(4'd3);
    D_addr = 8'h10;
    exp_q.push_back(ram_m[8'h10]);
    tick();
    tests++;
    if (D_rdata !== exp_q[0]) begin
      fails++;
      $display("FAIL ram_kept_over_reset: got %h expected %h", D_rdata, exp_q[0]);
    end
    void'(exp_q.pop_front());
  endtask

  initial begin
    test_reset();
    test_load();
    test_arith();
    test_store();
    test_dual_write();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
